cfg_regs: RTL and testbench

CFG_REGS -- requirements
Module: cfg_regs

---
 rtl/cfg_regs.sv | 115 +++++++++++
 tb/tb_cfg_regs.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cfg_regs.sv
// Configuration register block: CFG, optional SCRATCH, VERSION, with one-cycle ack/read pipeline.
// Optional SCRATCH storage at address 0x1 is enabled by defining CFG_REGS_SCRATCH_EN.
module cfg_regs (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  addr,
  input  logic        rd_wr,
  input  logic        req,
  input  logic [31:0] write_val,
  input  logic        cfg_ctrl_err,
  input  logic        cfg_ctrl_idle,
  output logic        cfg_port_enable,
  output logic [7:0]  cfg_port_id,
  output logic        ack,
  output logic [31:0] read_val
);

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] VERSION_VAL = 32'h0001_0000;

  logic              enable_bit;
  logic [7:0]        port_id_field;
  logic              err_bit;
  logic              idle_bit;
  logic              vld_p1;
  logic [DATA_W-1:0] read_val_p1;
  logic [DATA_W-1:0] rd_data;
  logic              wr_acc;
  logic              rd_acc;
  logic              wr_cfg;
  logic              unused_bits;

  assign wr_acc = req & ~rd_wr;
  assign rd_acc = req &  rd_wr;
  assign wr_cfg = wr_acc & (addr == 4'h0);

  // Bits that never reach storage in any build.
  assign unused_bits = ^{write_val[15:12], write_val[3:1]};

`ifdef CFG_REGS_SCRATCH_EN
  logic [DATA_W-1:0] scratch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr_acc && (addr == 4'h1)) begin
      scratch <= write_val;
    end
  end
`else
  logic unused_upper;
  assign unused_upper = ^{write_val[31:17]};
`endif

  // Read mux observes pre-edge register state, so a read right after a write sees the new value.
  always_comb begin
    rd_data = '0;
    case (addr)
      4'h0: rd_data = {14'b0, idle_bit, err_bit, 4'b0, port_id_field, 3'b0, enable_bit};
`ifdef CFG_REGS_SCRATCH_EN
      4'h1: rd_data = scratch;
`endif
      4'h2: rd_data = VERSION_VAL;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_bit    <= 1'b0;
      port_id_field <= '0;
    end else if (wr_cfg) begin
      enable_bit    <= write_val[0];
      port_id_field <= write_val[11:4];
    end
  end

  // Sticky error: a set from the controlled block wins over a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_bit <= 1'b0;
    end else if (cfg_ctrl_err) begin
      err_bit <= 1'b1;
    end else if (wr_cfg && write_val[16]) begin
      err_bit <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_bit <= 1'b0;
    end else begin
      idle_bit <= cfg_ctrl_idle;
    end
  end

  // Stage p1: ack and read data one cycle after the sampling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      read_val_p1 <= '0;
    end else begin
      vld_p1 <= req;
      if (rd_acc) begin
        read_val_p1 <= rd_data;
      end
    end
  end

  assign ack             = vld_p1;
  assign read_val        = read_val_p1;
  assign cfg_port_enable = enable_bit;
  assign cfg_port_id     = port_id_field;

endmodule

// File: tb/tb_cfg_regs.sv
// Directed table-driven bench for cfg_regs plus a reset-during-access sequence.
module tb_cfg_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr;
  logic        rd_wr;
  logic        req;
  logic [31:0] write_val;
  logic        cfg_ctrl_err;
  logic        cfg_ctrl_idle;
  logic        cfg_port_enable;
  logic [7:0]  cfg_port_id;
  logic        ack;
  logic [31:0] read_val;

  int total = 0;
  int bad   = 0;

  cfg_regs dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .rd_wr(rd_wr),
    .req(req),
    .write_val(write_val),
    .cfg_ctrl_err(cfg_ctrl_err),
    .cfg_ctrl_idle(cfg_ctrl_idle),
    .cfg_port_enable(cfg_port_enable),
    .cfg_port_id(cfg_port_id),
    .ack(ack),
    .read_val(read_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        rd_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        err_in;
    logic        idle_in;
    logic        exp_ack;
    logic [31:0] exp_rv;
    logic        exp_en;
    logic [7:0]  exp_id;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_ack, input logic [31:0] e_rv,
                            input logic e_en, input logic [7:0] e_id);
    check({tag, ".ack"}, {31'b0, ack}, {31'b0, e_ack});
    check({tag, ".read_val"}, read_val, e_rv);
    check({tag, ".enable"}, {31'b0, cfg_port_enable}, {31'b0, e_en});
    check({tag, ".port_id"}, {24'b0, cfg_port_id}, {24'b0, e_id});
  endtask

  logic [31:0] scratch_exp;

  initial begin
`ifdef CFG_REGS_SCRATCH_EN
    scratch_exp = 32'hA5A5_5A5A;
`else
    scratch_exp = 32'h0;
`endif
    //          req rw addr   wdata          err idl ack read_val       en id
    vecs[0]  = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 8'hFF};
    vecs[2]  = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0FF1, 1'b1, 8'hFF};
    vecs[3]  = '{1'b0, 1'b1, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 32'h0000_0FF1, 1'b1, 8'hFF};
    vecs[4]  = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0001_0FF1, 1'b1, 8'hFF};
    vecs[5]  = '{1'b1, 1'b0, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0001_0FF1, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[7]  = '{1'b1, 1'b0, 4'h0, 32'h0001_0000,  1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 32'h0001_0000,  1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h0001_0000,  1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[12] = '{1'b0, 1'b1, 4'h0, 32'h0,          1'b0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 8'h00};
    vecs[13] = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b1, 1'b1, 32'h0002_0000, 1'b0, 8'h00};
    vecs[14] = '{1'b0, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b0, 32'h0002_0000, 1'b0, 8'h00};
    vecs[15] = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[16] = '{1'b1, 1'b0, 4'h1, 32'hA5A5_5A5A,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[17] = '{1'b1, 1'b1, 4'h1, 32'h0,          1'b0, 1'b0, 1'b1, scratch_exp,   1'b0, 8'h00};
    vecs[18] = '{1'b1, 1'b1, 4'h2, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[19] = '{1'b1, 1'b0, 4'h2, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[20] = '{1'b1, 1'b1, 4'h2, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[21] = '{1'b1, 1'b0, 4'h7, 32'h1234_5678,  1'b0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 8'h00};
    vecs[22] = '{1'b1, 1'b1, 4'h7, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[23] = '{1'b1, 1'b0, 4'h0, 32'h0000_0235,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 8'h23};
    vecs[24] = '{1'b1, 1'b1, 4'h0, 32'h0,          1'b0, 1'b0, 1'b1, 32'h0000_0231, 1'b1, 8'h23};

    reset         = 1'b1;
    req           = 1'b0;
    rd_wr         = 1'b1;
    addr          = 4'h0;
    write_val     = 32'h0;
    cfg_ctrl_err  = 1'b0;
    cfg_ctrl_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outs("reset", 1'b0, 32'h0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check_outs("post_reset", 1'b0, 32'h0, 1'b0, 8'h00);

    // Back-to-back vectors: req stays high across consecutive access records.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      req           = vecs[i].req;
      rd_wr         = vecs[i].rd_wr;
      addr          = vecs[i].addr;
      write_val     = vecs[i].wdata;
      cfg_ctrl_err  = vecs[i].err_in;
      cfg_ctrl_idle = vecs[i].idle_in;
      @(posedge clk);
      #1 check_outs($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_rv,
                    vecs[i].exp_en, vecs[i].exp_id);
    end
    @(negedge clk);
    req          = 1'b0;
    cfg_ctrl_err = 1'b0;
    @(posedge clk);
    #1 check_outs("idle_after_vecs", 1'b0, 32'h0000_0231, 1'b1, 8'h23);

    // Reset right after a sampled write: the ack is dropped and everything clears.
    @(negedge clk);
    req       = 1'b1;
    rd_wr     = 1'b0;
    addr      = 4'h1;
    write_val = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_outs("rst_async", 1'b0, 32'h0, 1'b0, 8'h00);
    addr      = 4'h0;
    write_val = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1 check_outs("rst_req_ignored", 1'b0, 32'h0, 1'b0, 8'h00);
    @(negedge clk);
    req   = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1 check_outs("rst_no_late_ack", 1'b0, 32'h0, 1'b0, 8'h00);

    @(negedge clk);
    req   = 1'b1;
    rd_wr = 1'b1;
    addr  = 4'h0;
    @(posedge clk);
    #1 check_outs("rst_cfg_cleared", 1'b1, 32'h0, 1'b0, 8'h00);
    @(negedge clk);
    addr = 4'h1;
    @(posedge clk);
    #1 check_outs("rst_scratch_cleared", 1'b1, 32'h0, 1'b0, 8'h00);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1 check_outs("final_idle", 1'b0, 32'h0, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
